stopwatch_core: RTL and testbench

- Consumer stage directly downstream of the clock divider. Takes the divided slow-clock level as a data input, not as a clock.
- Synchronises that level into the board clock domain and detects its rising edges as count ticks.
- Runs the start/pause/clear state machine and keeps a BCD MM:SS count that drives the display decoder.

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/tick_edge_sync.sv | 40 ++++
 rtl/stopwatch_core.sv | 235 +++++++++++++++++++++++
 tb/tb_stopwatch_core.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and constants for the stopwatch core: the
//               control state encoding, the BCD digit type and the digit
//               wrap limits for the seconds / minutes-ones positions.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      OVF   = 2'd3
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t SEC_ONES_MAX = 4'd9;
   localparam bcd_t SEC_TENS_MAX = 4'd5;
   localparam bcd_t MIN_ONES_MAX = 4'd9;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/tick_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : tick_edge_sync
// Description : Brings an asynchronous slow level into the clk_in domain
//               through SYNC_STAGES flops, then emits a one-cycle pulse on
//               each rising edge of the synchronised level.
// Ports       : clk_in - sampling clock
//               rst    - asynchronous active-high reset
//               level  - asynchronous input level
//               pulse  - one clk_in cycle high per rising edge of level
// Revision    : 1.0 - initial release
// ============================================================================
module tick_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], level};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   // Pulse is valid in the cycle after the last sync flop goes high, so the
   // consumer acts on the (SYNC_STAGES+1)th edge after the first high sample.
   assign pulse = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule : tick_edge_sync
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_core
// Description : Start/pause/clear stopwatch with a BCD MM:SS count. The
//               divided slow clock arrives as a data level on tick_in; each
//               synchronised rising edge is one count tick.
// Ports       : clk_in          - board clock, the only clock
//               rst             - asynchronous active-high reset
//               tick_in         - divided clock level (asynchronous)
//               btn_start_stop  - debounced start/pause level
//               btn_clear       - debounced clear level
//               btn_lap         - debounced lap level (STOPWATCH_LAP_EN only)
//               sec_ones..min_tens - BCD display digits
//               running         - high in RUN
//               overflow        - high in OVF
//               lap_active      - lap freeze shown (STOPWATCH_LAP_EN only)
// Options     : STOPWATCH_LAP_EN - adds the lap-freeze display feature
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int MAX_MIN_TENS = 5
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
`ifdef STOPWATCH_LAP_EN
   input  logic       btn_lap,
   output logic       lap_active,
`endif
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       overflow
);

   localparam bcd_t c_min_tens_max = bcd_t'(MAX_MIN_TENS);

   state_t r_state;
   state_t w_state_next;

   bcd_t r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;

   logic w_tick;
   logic r_start_prev, r_clear_prev;
   logic w_start_press, w_clear_press;
   logic w_at_max;
   logic w_ovf_entry;
   logic w_inc;
   logic w_clear_digits;

   // ------------------------------------------------------------------------
   // Tick synchroniser / edge detector
   // ------------------------------------------------------------------------
   tick_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_tick_sync (
      .clk_in (clk_in),
      .rst    (rst),
      .level  (tick_in),
      .pulse  (w_tick)
   );

   // ------------------------------------------------------------------------
   // Button press detection: one press per low-to-high transition
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_start_prev <= 1'b0;
         r_clear_prev <= 1'b0;
      end else begin
         r_start_prev <= btn_start_stop;
         r_clear_prev <= btn_clear;
      end
   end

   assign w_start_press = btn_start_stop & ~r_start_prev;
   assign w_clear_press = btn_clear & ~r_clear_prev;

   assign w_at_max = (r_min_tens == c_min_tens_max) &&
                     (r_min_ones == MIN_ONES_MAX)   &&
                     (r_sec_tens == SEC_TENS_MAX)   &&
                     (r_sec_ones == SEC_ONES_MAX);

   // The final carry goes to OVF instead of wrapping the count.
   assign w_ovf_entry = (r_state == RUN) && w_tick && w_at_max;

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_inc          = 1'b0;
      w_clear_digits = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_clear_press) begin
               w_clear_digits = 1'b1;
            end else if (w_start_press) begin
               w_state_next = RUN;
            end
         end
         RUN: begin
            // Clear is ignored while running; start takes priority.
            if (w_ovf_entry) begin
               w_state_next = OVF;
            end else begin
               w_inc = w_tick;
               if (w_start_press) begin
                  w_state_next = PAUSE;
               end
            end
         end
         PAUSE: begin
            if (w_clear_press) begin
               w_state_next   = IDLE;
               w_clear_digits = 1'b1;
            end else if (w_start_press) begin
               w_state_next = RUN;
            end
         end
         OVF: begin
            if (w_clear_press) begin
               w_state_next   = IDLE;
               w_clear_digits = 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // BCD count with ripple carry; w_inc is never set at full scale
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_sec_ones <= '0;
         r_sec_tens <= '0;
         r_min_ones <= '0;
         r_min_tens <= '0;
      end else if (w_clear_digits) begin
         r_sec_ones <= '0;
         r_sec_tens <= '0;
         r_min_ones <= '0;
         r_min_tens <= '0;
      end else if (w_inc) begin
         if (r_sec_ones == SEC_ONES_MAX) begin
            r_sec_ones <= '0;
            if (r_sec_tens == SEC_TENS_MAX) begin
               r_sec_tens <= '0;
               if (r_min_ones == MIN_ONES_MAX) begin
                  r_min_ones <= '0;
                  r_min_tens <= r_min_tens + 4'd1;
               end else begin
                  r_min_ones <= r_min_ones + 4'd1;
               end
            end else begin
               r_sec_tens <= r_sec_tens + 4'd1;
            end
         end else begin
            r_sec_ones <= r_sec_ones + 4'd1;
         end
      end
   end

   assign running  = (r_state == RUN);
   assign overflow = (r_state == OVF);

`ifdef STOPWATCH_LAP_EN
   // ------------------------------------------------------------------------
   // Lap freeze: snapshot of the live digits shown while the count runs on
   // ------------------------------------------------------------------------
   logic r_lap_prev;
   logic r_lap_active;
   logic w_lap_press;
   bcd_t r_lap_sec_ones, r_lap_sec_tens, r_lap_min_ones, r_lap_min_tens;

   assign w_lap_press = btn_lap & ~r_lap_prev;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_lap_prev     <= 1'b0;
         r_lap_active   <= 1'b0;
         r_lap_sec_ones <= '0;
         r_lap_sec_tens <= '0;
         r_lap_min_ones <= '0;
         r_lap_min_tens <= '0;
      end else begin
         r_lap_prev <= btn_lap;
         if (w_ovf_entry || w_clear_digits) begin
            r_lap_active <= 1'b0;
         end else if ((r_state == RUN) && w_lap_press) begin
            if (r_lap_active) begin
               r_lap_active <= 1'b0;
            end else begin
               r_lap_active   <= 1'b1;
               r_lap_sec_ones <= r_sec_ones;
               r_lap_sec_tens <= r_sec_tens;
               r_lap_min_ones <= r_min_ones;
               r_lap_min_tens <= r_min_tens;
            end
         end
      end
   end

   assign lap_active = r_lap_active;
   assign sec_ones   = r_lap_active ? r_lap_sec_ones : r_sec_ones;
   assign sec_tens   = r_lap_active ? r_lap_sec_tens : r_sec_tens;
   assign min_ones   = r_lap_active ? r_lap_min_ones : r_min_ones;
   assign min_tens   = r_lap_active ? r_lap_min_tens : r_min_tens;
`else
   assign sec_ones = r_sec_ones;
   assign sec_tens = r_sec_tens;
   assign min_ones = r_min_ones;
   assign min_tens = r_min_tens;
`endif

endmodule : stopwatch_core
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_core
// Description : Scoreboard bench for stopwatch_core. Each stimulus cycle
//               pushes the reference model's expected outputs; a monitor on
//               the falling edge pops and compares against the DUT.
// Options     : STOPWATCH_LAP_EN - also exercises the lap feature
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_core;

   localparam int SYNC_STAGES  = 2;
   localparam int MAX_MIN_TENS = 5;
   localparam int MAX_COUNT    = MAX_MIN_TENS * 600 + 9 * 60 + 59;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic       clk_in = 1'b0;
   logic       rst    = 1'b1;
   logic       tick_in = 1'b0;
   logic       btn_start_stop = 1'b0;
   logic       btn_clear = 1'b0;
   logic       btn_lap = 1'b0;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic       running, overflow, lap_active;

   always #5 clk_in = ~clk_in;

   stopwatch_core #(
      .SYNC_STAGES  (SYNC_STAGES),
      .MAX_MIN_TENS (MAX_MIN_TENS)
   ) dut (
      .clk_in         (clk_in),
      .rst            (rst),
      .tick_in        (tick_in),
      .btn_start_stop (btn_start_stop),
      .btn_clear      (btn_clear),
`ifdef STOPWATCH_LAP_EN
      .btn_lap        (btn_lap),
      .lap_active     (lap_active),
`endif
      .sec_ones       (sec_ones),
      .sec_tens       (sec_tens),
      .min_ones       (min_ones),
      .min_tens       (min_tens),
      .running        (running),
      .overflow       (overflow)
   );
`ifndef STOPWATCH_LAP_EN
   assign lap_active = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] mt, mo, st, so;
      logic       run, ovf, lap;
   } obs_t;

   obs_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc_no = 0;

   // ------------------------------------------------------------------------
   // Reference model: total elapsed seconds plus a coarse mode value
   // ------------------------------------------------------------------------
   int m_mode;          // 0 idle, 1 run, 2 pause, 3 overflow
   int m_count;         // seconds elapsed, 0..MAX_COUNT
   int m_disp;          // frozen lap value in seconds
   bit m_lap;
   bit m_pst, m_pcl, m_plp;
   bit m_samp[$];       // recent tick_in samples, oldest first

   task automatic model_reset();
      m_mode = 0; m_count = 0; m_disp = 0; m_lap = 0;
      m_pst = 0; m_pcl = 0; m_plp = 0;
      m_samp = {};
      for (int i = 0; i <= SYNC_STAGES; i++) m_samp.push_back(1'b0);
   endtask

   // A tick is seen SYNC_STAGES edges after tick_in was first sampled high.
   task automatic model_edge(input bit ti, input bit st, input bit cl, input bit lp);
      bit tk, sp, cp, lpp, ovf_now;
      m_samp.push_back(ti);
      tk = m_samp[1] && !m_samp[0];
      void'(m_samp.pop_front());
      sp = st && !m_pst;
      cp = cl && !m_pcl;
      lpp = LAP_EN && lp && !m_plp;
      m_pst = st; m_pcl = cl; m_plp = lp;
      case (m_mode)
         0: begin
            if (cp) begin m_count = 0; m_lap = 0; end
            else if (sp) m_mode = 1;
         end
         1: begin
            ovf_now = tk && (m_count == MAX_COUNT);
            if (lpp) begin
               if (m_lap) m_lap = 0;
               else begin m_disp = m_count; m_lap = 1; end
            end
            if (ovf_now) begin m_mode = 3; m_lap = 0; end
            else begin
               if (tk) m_count++;
               if (sp) m_mode = 2;
            end
         end
         default: begin
            if (cp) begin m_mode = 0; m_count = 0; m_lap = 0; end
            else if (sp && m_mode == 2) m_mode = 1;
         end
      endcase
   endtask

   function automatic obs_t model_out();
      obs_t o;
      int shown, mins, secs;
      shown = m_lap ? m_disp : m_count;
      mins  = shown / 60;
      secs  = shown % 60;
      o.mt  = 4'(mins / 10);
      o.mo  = 4'(mins % 10);
      o.st  = 4'(secs / 10);
      o.so  = 4'(secs % 10);
      o.run = (m_mode == 1);
      o.ovf = (m_mode == 3);
      o.lap = m_lap;
      return o;
   endfunction

   task automatic check_obs(input string name, input obs_t e);
      obs_t a;
      a = '{mt: min_tens, mo: min_ones, st: sec_tens, so: sec_ones,
            run: running, ovf: overflow, lap: lap_active};
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s cycle=%0d actual=%h%h:%h%h run=%b ovf=%b lap=%b required=%h%h:%h%h run=%b ovf=%b lap=%b",
                  name, cyc_no, a.mt, a.mo, a.st, a.so, a.run, a.ovf, a.lap,
                  e.mt, e.mo, e.st, e.so, e.run, e.ovf, e.lap);
      end
   endtask

   // Monitor: outputs settle after each active edge, compared on the next fall.
   always @(negedge clk_in) begin
      if (exp_q.size() > 0) begin
         check_obs("scoreboard", exp_q.pop_front());
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic cyc(input bit ti, input bit st, input bit cl, input bit lp);
      @(negedge clk_in);
      tick_in = ti; btn_start_stop = st; btn_clear = cl; btn_lap = lp;
      @(posedge clk_in);
      cyc_no++;
      model_edge(ti, st, cl, lp);
      exp_q.push_back(model_out());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic press(input bit st, input bit cl, input bit lp);
      cyc(1'b0, st, cl, lp);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Raises tick_in so that its pulse coincides with a start press.
   task automatic tick_with_start();
      for (int i = 0; i < SYNC_STAGES; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      obs_t zero_obs;
      bit   r_st, r_cl, r_lp;
      zero_obs = '0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check_obs("reset_state", zero_obs);
      rst = 1'b0;

      // Start, then three ticks
      idle(2);
      press(1'b1, 1'b0, 1'b0);
      ticks(3);
      idle(4);

      // Carry chain: 00:58 -> 00:59 -> 01:00, 09:59 -> 10:00
      ticks(55); idle(4);
      ticks(1);  idle(4);
      ticks(1);  idle(4);
      ticks(539); idle(4);
      ticks(1);  idle(4);

      // Full scale and overflow
      ticks(MAX_COUNT - 600); idle(4);
      ticks(1); idle(4);
      ticks(2); idle(4);
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      idle(2);

      // Pause discards ticks
      press(1'b1, 1'b0, 1'b0);
      ticks(5); idle(4);
      press(1'b1, 1'b0, 1'b0);
      ticks(4); idle(4);
      press(1'b1, 1'b0, 1'b0);
      ticks(1); idle(4);

      // Tick and start on the same edge in RUN at 00:10
      ticks(4); idle(4);
      tick_with_start();
      idle(3);
      // Tick and start on the same edge in PAUSE
      tick_with_start();
      idle(3);
      // Start and clear together in RUN, then in PAUSE
      press(1'b1, 1'b1, 1'b0);
      idle(2);
      press(1'b1, 1'b1, 1'b0);
      idle(2);
      // A held button is a single press
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);

      // Lap freeze
      press(1'b1, 1'b0, 1'b0);
      ticks(7); idle(4);
      press(1'b0, 1'b0, 1'b1);
      ticks(5); idle(4);
      press(1'b0, 1'b0, 1'b1);
      idle(2);
      press(1'b0, 1'b0, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      ticks(2); idle(4);
      press(1'b0, 1'b1, 1'b0);
      idle(2);

      // Randomised traffic with slowly changing button levels
      r_st = 0; r_cl = 0; r_lp = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0)  r_st = ~r_st;
         if ($urandom_range(0, 29) == 0) r_cl = ~r_cl;
         if ($urandom_range(0, 14) == 0) r_lp = ~r_lp;
         cyc(1'($urandom_range(0, 1)), r_st, r_cl, r_lp);
      end
      idle(4);

      // Asynchronous reset mid-run, with tick_in held high across release
      press(1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      ticks(6); idle(4);
      press(1'b0, 1'b0, 1'b1);
      idle(1);
      @(negedge clk_in);
      @(posedge clk_in);
      #2;
      rst = 1'b1;
      tick_in = 1'b1;
      #1;
      check_obs("async_reset", zero_obs);
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      check_obs("reset_hold", zero_obs);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      ticks(2); idle(4);

      repeat (2) @(negedge clk_in);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_stopwatch_core
`default_nettype wire
